// File: rtl/dvk_sdram_pkg.sv
// Shared definitions for the SDRAM Wishbone initiator.
//   - FSM state encoding (IDLE / ISSUE / RELEASE)
//   - Posted-write entry layout {adr[21:1], sel[1:0], dat[15:0]}, 39 bits
//   - Data returned to the bus when the controller never acknowledges a read
package dvk_sdram_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam int WENTRY_W = 39;

    localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

    typedef struct packed {
        logic [20:0] adr;
        logic [1:0]  sel;
        logic [15:0] dat;
    } wentry_t;

    function automatic wentry_t make_wentry(input logic [20:0] adr,
                                            input logic [1:0]  sel,
                                            input logic [15:0] dat);
        wentry_t e;
        e.adr = adr;
        e.sel = sel;
        e.dat = dat;
        return e;
    endfunction

endpackage

// File: rtl/sdram_wbuf.sv
// Posted-write buffer: a small synchronous FIFO of write entries.
// Ports:
//   clk, srst      clock, synchronous active-high reset (empties the buffer)
//   i_push/i_data  enqueue one entry
//   i_pop          dequeue the head entry
//   o_head         head entry (combinational view of the oldest entry)
//   o_full/o_empty occupancy flags, o_count current occupancy
// A push and a pop in the same cycle are both honoured, even when full.
module sdram_wbuf
    import dvk_sdram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    i_push,
    input  logic [WENTRY_W-1:0]     i_data,
    input  logic                    i_pop,
    output logic [WENTRY_W-1:0]     o_head,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [WENTRY_W-1:0] w_mem [DEPTH];
    logic                w_do_push;
    logic                w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // The buffer is only a handful of entries, so each one is a plain
    // register and the head is read without a pipeline stage.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic [WENTRY_W-1:0] r_ent;
            always_ff @(posedge clk) begin
                if (w_do_push && (r_wr_ptr == AW'(gi))) begin
                    r_ent <= i_data;
                end
            end
            assign w_mem[gi] = r_ent;
        end
    endgenerate

    assign o_head = w_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_wb_initiator.sv
// Wishbone slave to SDRAM request-port initiator.
// Writes are posted into a small buffer (acked one cycle after the request)
// and drained in order; reads block until the buffer is empty, so a read
// never overtakes an older write. A watchdog forces completion when the
// controller stops acknowledging, and sdram_reset is stretched past reset.
// Ports:
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   wb_adr_i/dat_i/we_i/sel_i    Wishbone request, wb_cyc_i/wb_stb_i qualify
//   wb_dat_o, wb_ack_o           read data, single-cycle acknowledge
//   sdram_stb/we/sel/adr/out     request port to the SDRAM controller bridge
//   sdram_dat, sdram_ack         controller response
//   sdram_ready                  controller initialisation done
//   sdram_reset                  stretched controller reset
//   tmo_err                      sticky watchdog-expired flag
module sdram_wb_initiator
    import dvk_sdram_pkg::*;
#(
    parameter int WBUF_DEPTH = 2,
    parameter int TIMEOUT    = 1023,
    parameter int RST_HOLD   = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [21:1] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        sdram_reset,
    output logic        sdram_stb,
    output logic        sdram_we,
    output logic [1:0]  sdram_sel,
    output logic [21:1] sdram_adr,
    output logic [15:0] sdram_out,
    input  logic [15:0] sdram_dat,
    input  logic        sdram_ack,
    input  logic        sdram_ready,
    output logic        tmo_err
);

    localparam int WD_RAW = $clog2(TIMEOUT + 1);
    localparam int WD_W   = (WD_RAW > 10) ? WD_RAW : 10;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    localparam int RC_RAW = $clog2(RST_HOLD + 1);
    localparam int RC_W   = (RC_RAW > 1) ? RC_RAW : 1;
    localparam logic [RC_W-1:0] RC_INIT = RC_W'(RST_HOLD);
    localparam int CW = $clog2(WBUF_DEPTH) + 1;

    logic [1:0]      r_state;
    logic            r_ack;
    logic [15:0]     r_dat;
    logic            r_stb;
    logic            r_we;
    logic [1:0]      r_sel;
    logic [21:1]     r_adr;
    logic [15:0]     r_out;
    logic            r_tmo;
    logic            r_is_read;
    logic [WD_W-1:0] r_wd;
    logic [RC_W-1:0] r_rst_cnt;

    logic            w_req;
    logic            w_push;
    logic            w_pop;
    logic            w_done;
    logic            w_timeout;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [WENTRY_W-1:0] w_head_bits;
    wentry_t         w_head;

    // The ack register masks the request so a master still holding stb
    // during the ack cycle is not accepted twice.
    assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_timeout = (r_wd == WD_MAX);
    assign w_done    = (r_state == ST_ISSUE) & (sdram_ack | w_timeout);
    assign w_pop     = w_done & ~r_is_read;
    // A pop in the same cycle frees the slot a full buffer needs.
    assign w_push    = w_req & wb_we_i & (~w_full | w_pop);
    assign w_head    = wentry_t'(w_head_bits);

    sdram_wbuf #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk     (wb_clk_i),
        .srst    (wb_rst_i),
        .i_push  (w_push),
        .i_data  (make_wentry(wb_adr_i, wb_sel_i, wb_dat_i)),
        .i_pop   (w_pop),
        .o_head  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_adr     <= '0;
            r_out     <= '0;
            r_tmo     <= 1'b0;
            r_is_read <= 1'b0;
            r_wd      <= '0;
        end else begin
            r_ack <= w_push | (w_done & r_is_read);
            case (r_state)
                ST_IDLE: begin
                    if (sdram_ready && (w_count != '0)) begin
                        // Posted writes always drain before any read.
                        r_adr     <= w_head.adr;
                        r_sel     <= w_head.sel;
                        r_out     <= w_head.dat;
                        r_we      <= 1'b1;
                        r_is_read <= 1'b0;
                        r_stb     <= 1'b1;
                        r_wd      <= '0;
                        r_state   <= ST_ISSUE;
                    end else if (sdram_ready && w_empty && w_req && !wb_we_i) begin
                        r_adr     <= wb_adr_i;
                        r_sel     <= 2'b11;
                        r_we      <= 1'b0;
                        r_is_read <= 1'b1;
                        r_stb     <= 1'b1;
                        r_wd      <= '0;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_done) begin
                        r_stb   <= 1'b0;
                        r_state <= ST_RELEASE;
                        if (!sdram_ack) begin
                            r_tmo <= 1'b1;
                        end
                        if (r_is_read) begin
                            r_dat <= sdram_ack ? sdram_dat : TIMEOUT_DATA;
                        end
                    end else if (!w_timeout) begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // The controller holds ack while stb was high; wait for
                    // it to clear so the next strobe is seen as new.
                    if (!sdram_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rst_cnt <= RC_INIT;
        end else if (r_rst_cnt != '0) begin
            r_rst_cnt <= r_rst_cnt - 1'b1;
        end
    end

    assign sdram_reset = (r_rst_cnt != '0);
    assign wb_ack_o    = r_ack;
    assign wb_dat_o    = r_dat;
    assign sdram_stb   = r_stb;
    assign sdram_we    = r_we;
    assign sdram_sel   = r_sel;
    assign sdram_adr   = r_adr;
    assign sdram_out   = r_out;
    assign tmo_err     = r_tmo;

endmodule

// File: tb/tb_sdram_wb_initiator.sv
module tb_sdram_wb_initiator;

    localparam int TIMEOUT  = 1023;
    localparam int RST_HOLD = 4;
    localparam int BOUND    = 3000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [21:1] wb_adr_i = '0;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i  = 1'b0;
    logic [1:0]  wb_sel_i = '0;
    logic        wb_ack_o;
    logic        sdram_reset;
    logic        sdram_stb;
    logic        sdram_we;
    logic [1:0]  sdram_sel;
    logic [21:1] sdram_adr;
    logic [15:0] sdram_out;
    logic [15:0] sdram_dat   = '0;
    logic        sdram_ack   = 1'b0;
    logic        sdram_ready = 1'b0;
    logic        tmo_err;

    sdram_wb_initiator #(
        .WBUF_DEPTH (2),
        .TIMEOUT    (TIMEOUT),
        .RST_HOLD   (RST_HOLD)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_we_i     (wb_we_i),
        .wb_sel_i    (wb_sel_i),
        .wb_ack_o    (wb_ack_o),
        .sdram_reset (sdram_reset),
        .sdram_stb   (sdram_stb),
        .sdram_we    (sdram_we),
        .sdram_sel   (sdram_sel),
        .sdram_adr   (sdram_adr),
        .sdram_out   (sdram_out),
        .sdram_dat   (sdram_dat),
        .sdram_ack   (sdram_ack),
        .sdram_ready (sdram_ready),
        .tmo_err     (tmo_err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic        we;
        logic [20:0] adr;
        logic [1:0]  sel;
        logic [15:0] dat;
    } sd_txn_t;

    sd_txn_t     exp_sd_q[$];
    logic [15:0] exp_rd_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Controller model knobs and bookkeeping.
    int          ctl_lat    = 2;
    int          ctl_hold   = 0;
    bit          ctl_noack  = 1'b0;
    logic [15:0] ctl_rdata  = '0;
    bit          busy       = 1'b0;
    int          wait_cnt   = 0;
    int          hold_left  = 0;
    int          n_txn      = 0;
    int          ack_set_cyc = -1;
    logic [39:0] cur_req    = '0;

    always @(posedge wb_clk_i) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Behavioural SDRAM controller bridge, driven on the falling edge.
    always @(negedge wb_clk_i) begin
        sd_txn_t e;
        if (sdram_stb) begin
            if (!busy) begin
                busy = 1'b1;
                wait_cnt = 0;
                n_txn++;
                chk("stb_needs_ack_low", sdram_ack, 1'b0);
                chk("sd_q_nonempty", exp_sd_q.size() != 0, 1'b1);
                if (exp_sd_q.size() != 0) begin
                    e = exp_sd_q.pop_front();
                    chk("sd_we", sdram_we, e.we);
                    chk("sd_adr", sdram_adr, e.adr);
                    chk("sd_sel", e.we ? sdram_sel : sdram_sel, e.we ? e.sel : 2'b11);
                    if (e.we) chk("sd_out", sdram_out, e.dat);
                end
                cur_req = {sdram_we, sdram_adr, sdram_sel, sdram_out};
            end else begin
                chk("sd_stable", {sdram_we, sdram_adr, sdram_sel, sdram_out}, cur_req);
                if (!sdram_ack) wait_cnt++;
            end
            if (!sdram_ack && !ctl_noack && wait_cnt >= ctl_lat) begin
                sdram_ack   = 1'b1;
                sdram_dat   = ctl_rdata;
                hold_left   = ctl_hold;
                ack_set_cyc = cyc;
            end
        end else begin
            busy = 1'b0;
            if (sdram_ack) begin
                if (hold_left > 0) hold_left--;
                else sdram_ack = 1'b0;
            end
        end
    end

    task automatic wb_write(input logic [20:0] adr, input logic [15:0] dat,
                            input logic [1:0] sel, output int lat, output int ack_cyc);
        sd_txn_t t;
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        t.we = 1'b1; t.adr = adr; t.sel = sel; t.dat = dat;
        exp_sd_q.push_back(t);
        lat = 0;
        do begin
            @(negedge wb_clk_i);
            lat++;
        end while (!wb_ack_o && lat < BOUND);
        chk("wr_ack_seen", wb_ack_o, 1'b1);
        ack_cyc = cyc;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        $display("WR adr=%06h dat=%04h sel=%b ack_latency=%0d", adr, dat, sel, lat);
    endtask

    task automatic wb_read(input logic [20:0] adr, input logic [15:0] exp_dat, output int lat);
        sd_txn_t t;
        logic [15:0] d;
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = adr;  wb_sel_i = 2'b11;
        t.we = 1'b0; t.adr = adr; t.sel = 2'b11; t.dat = '0;
        exp_sd_q.push_back(t);
        exp_rd_q.push_back(exp_dat);
        lat = 0;
        do begin
            @(negedge wb_clk_i);
            lat++;
        end while (!wb_ack_o && lat < BOUND);
        chk("rd_ack_seen", wb_ack_o, 1'b1);
        d = exp_rd_q.pop_front();
        chk("rd_data", wb_dat_o, d);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        $display("RD adr=%06h dat=%04h ack_latency=%0d", adr, wb_dat_o, lat);
        @(negedge wb_clk_i);
        chk("rd_ack_single", wb_ack_o, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_sd_q.size() != 0 || sdram_stb || sdram_ack) && n < BOUND) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("drain_done", n < BOUND, 1'b1);
    endtask

    task automatic check_stretch(input string tag);
        for (int i = 0; i < RST_HOLD; i++) begin
            chk(tag, sdram_reset, 1'b1);
            @(negedge wb_clk_i);
        end
        chk({tag, "_end"}, sdram_reset, 1'b0);
    endtask

    initial begin
        int lat, lat1, lat2, lat3, ack_cyc, n0;
        bit seen;

        // Reset with the controller not yet ready.
        repeat (3) @(negedge wb_clk_i);
        chk("rst_ack", wb_ack_o, 1'b0);
        chk("rst_dat", wb_dat_o, 16'h0);
        chk("rst_stb", sdram_stb, 1'b0);
        chk("rst_we", sdram_we, 1'b0);
        chk("rst_sel", sdram_sel, 2'b00);
        chk("rst_adr", sdram_adr, 21'h0);
        chk("rst_out", sdram_out, 16'h0);
        chk("rst_tmo", tmo_err, 1'b0);
        chk("rst_sdram_reset", sdram_reset, 1'b1);
        wb_rst_i = 1'b0;
        check_stretch("rst_stretch");

        // Write posted while controller not ready; drains once ready.
        ctl_lat = 2;
        n0 = n_txn;
        wb_write(21'h00100, 16'h1234, 2'b11, lat, ack_cyc);
        chk("t1_wr_latency", lat, 1);
        repeat (5) @(negedge wb_clk_i);
        chk("t1_no_stb_unready", n_txn, n0);
        sdram_ready = 1'b1;
        wait_idle();
        chk("t1_one_txn", n_txn, n0 + 1);

        // Read with 5-cycle controller latency and ack held 3 extra cycles,
        // followed straight away by a write that must wait for ack low.
        ctl_lat = 5; ctl_hold = 3; ctl_rdata = 16'hBEEF;
        wb_read(21'h00300, 16'hBEEF, lat);
        wb_write(21'h00301, 16'h0F0F, 2'b01, lat, ack_cyc);
        chk("t2_wr_latency", lat, 1);
        wait_idle();
        ctl_hold = 0;

        // Three back-to-back writes, slow controller: third stalls on full.
        ctl_lat = 20;
        wb_write(21'h00400, 16'h1111, 2'b01, lat1, ack_cyc);
        wb_write(21'h00401, 16'h2222, 2'b10, lat2, ack_cyc);
        wb_write(21'h00402, 16'h3333, 2'b11, lat3, ack_cyc);
        chk("t3_w1_latency", lat1, 1);
        chk("t3_w2_latency", lat2, 1);
        chk("t3_w3_stalled", lat3 > 1, 1'b1);
        chk("t3_w3_ack_after_pop", ack_cyc, ack_set_cyc + 1);
        wait_idle();

        // Write then read of the same address: read is ordered behind it.
        ctl_lat = 3; ctl_rdata = 16'h5A5A;
        wb_write(21'h00200, 16'hA5A5, 2'b11, lat, ack_cyc);
        wb_read(21'h00200, 16'h5A5A, lat);
        wait_idle();

        // Controller never acks a read: watchdog forces completion.
        chk("t5_tmo_before", tmo_err, 1'b0);
        ctl_noack = 1'b1;
        wb_read(21'h00040, 16'hFFFF, lat);
        chk("t5_tmo_set", tmo_err, 1'b1);
        chk("t5_tmo_latency", (lat >= TIMEOUT) && (lat <= TIMEOUT + 4), 1'b1);
        ctl_noack = 1'b0;
        wait_idle();
        ctl_lat = 1; ctl_rdata = 16'h1357;
        wb_write(21'h00041, 16'h2468, 2'b10, lat, ack_cyc);
        wb_read(21'h00042, 16'h1357, lat);
        wait_idle();
        chk("t5_tmo_sticky", tmo_err, 1'b1);

        // Reset while stb is high with two writes buffered.
        ctl_lat = 60;
        wb_write(21'h00500, 16'hAAAA, 2'b11, lat, ack_cyc);
        wb_write(21'h00501, 16'hBBBB, 2'b11, lat, ack_cyc);
        chk("t6_stb_high", sdram_stb, 1'b1);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("t6_stb_dropped", sdram_stb, 1'b0);
        chk("t6_no_ack", wb_ack_o, 1'b0);
        chk("t6_tmo_cleared", tmo_err, 1'b0);
        chk("t6_sdram_reset", sdram_reset, 1'b1);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        exp_sd_q.delete();
        check_stretch("t6_stretch");
        n0 = n_txn;
        seen = 1'b0;
        repeat (20) begin
            @(negedge wb_clk_i);
            if (wb_ack_o) seen = 1'b1;
        end
        chk("t6_buffer_discarded", n_txn, n0);
        chk("t6_no_late_ack", seen, 1'b0);
        ctl_lat = 2; ctl_rdata = 16'hC0DE;
        wb_write(21'h00600, 16'h7777, 2'b01, lat, ack_cyc);
        wb_read(21'h00601, 16'hC0DE, lat);
        wait_idle();
        chk("t6_resume_txns", n_txn, n0 + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "global timeout");
    end

endmodule
